// File: rtl/timed_decoder_pkg.sv
// -----------------------------------------------------------------------------
// timed_decoder_pkg
//   Shared types and helpers for the timed one-hot decoder.
//   - state_t    : FSM encoding (IDLE / DRIVE / GAP)
//   - onehot()   : index -> one-hot vector, zero for indices >= width
//   - cnt_width(): counter width able to hold max(hold, gap, 2) - 1
// -----------------------------------------------------------------------------
package timed_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int MAX_OUT = 256;

  // Returns a MAX_OUT-wide one-hot word; callers truncate to their own width.
  // Codes at or beyond `width` decode to all-zero, which is how out-of-range
  // codes end up behaving like the "no request" token.
  function automatic logic [MAX_OUT-1:0] onehot(input int unsigned code,
                                                input int unsigned width);
    logic [MAX_OUT-1:0] v;
    v = '0;
    if (code < width) v[code] = 1'b1;
    return v;
  endfunction

  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = 2;
    if (hold > m) m = hold;
    if (gap > m) m = gap;
    return $clog2(m);
  endfunction

  // Counter width for the default configuration (HOLD_CYCLES=4, GAP_CYCLES=1).
  localparam int DEF_CNT_W = cnt_width(4, 1);

endpackage

// File: rtl/timed_decoder_onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
//   Purely combinational, enable-gated N_OUT-line decoder.
//   Ports:
//     en           : gate; when low, y is all-zero and out_of_range is low
//     code         : index to decode
//     none         : "no request" token, forces y to zero (wins over code)
//     y            : one-hot (or all-zero) result
//     out_of_range : code >= N_OUT while enabled and not `none`
// -----------------------------------------------------------------------------
module onehot_dec
  import timed_decoder_pkg::*;
#(
  parameter int N_OUT  = 8,
  parameter int CODE_W = $clog2(N_OUT)
) (
  input  logic              en,
  input  logic [CODE_W-1:0] code,
  input  logic              none,
  output logic [N_OUT-1:0]  y,
  output logic              out_of_range
);

  logic [MAX_OUT-1:0] full;

  // Gating on `en` keeps an undriven/X code from reaching y when nothing is
  // being accepted.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned -- that is what prevents latch inference.
  always_comb begin
    full         = '0;
    out_of_range = 1'b0;
    if (en && !none) begin
      full         = onehot(32'(code), N_OUT);
      out_of_range = (32'(code) >= N_OUT);
    end
  end

  assign y = N_OUT'(full);

endmodule

// File: rtl/timed_decoder.sv
// -----------------------------------------------------------------------------
// timed_decoder
//   Accepts an encoded index over valid/ready and drives the matching one-hot
//   line for HOLD_CYCLES cycles, followed by GAP_CYCLES forced-zero cycles.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     en        : global enable; low aborts activity and blocks acceptance
//     in_valid  : code/none presented
//     in_ready  : can accept (combinational, only in IDLE)
//     in_code   : index to decode
//     in_none   : "no request" token, holds with all outputs low
//     y         : registered one-hot output
//     busy      : high in DRIVE or GAP
//     done      : one-cycle pulse as a hold completes normally
//     err       : one-cycle pulse after an out-of-range code is accepted
// -----------------------------------------------------------------------------
module timed_decoder
  import timed_decoder_pkg::*;
#(
  parameter int N_OUT       = 8,
  parameter int CODE_W      = $clog2(N_OUT),
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_none,
  output logic [N_OUT-1:0]  y,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W  = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int HOLD_M1 = HOLD_CYCLES - 1;
  // Guarded so a zero gap never produces a negative reload constant.
  localparam int GAP_M1  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic [N_OUT-1:0]   dec_y;
  logic               dec_oor;

  assign accept = in_valid && in_ready;

  onehot_dec #(
    .N_OUT  (N_OUT),
    .CODE_W (CODE_W)
  ) u_dec (
    .en           (accept),
    .code         (in_code),
    .none         (in_none),
    .y            (dec_y),
    .out_of_range (dec_oor)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. Dropping en aborts straight back to IDLE.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_d = DRIVE;
        DRIVE:   if (cnt_q == '0) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        GAP:     if (cnt_q == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore-style outputs. in_ready is held low during reset so nothing is
  // consumed on an edge that is discarding state anyway.
  always_comb begin
    in_ready = !rst && en && (state_q == IDLE);
    busy     = (state_q != IDLE);
  end

  // Counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      y     <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (!en) begin
        cnt_q <= '0;
        y     <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (accept) begin
              y     <= dec_y;
              err   <= dec_oor;
              cnt_q <= CNT_W'(HOLD_M1);
            end
          end
          DRIVE: begin
            if (cnt_q == '0) begin
              y     <= '0;
              done  <= 1'b1;
              cnt_q <= CNT_W'(GAP_M1);
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          GAP: begin
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
          end
          default: begin
            cnt_q <= '0;
            y     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timed_decoder.sv
// -----------------------------------------------------------------------------
// tb_timed_decoder
//   Directed bench for timed_decoder. Instance A uses the defaults
//   (N_OUT=8, HOLD=4, GAP=1); instance B uses N_OUT=6, HOLD=1, GAP=0 to reach
//   out-of-range codes. Inputs change and outputs are sampled on the falling
//   edge; "cycle k" means the cycle after the k-th rising edge since the
//   accepting edge.
// -----------------------------------------------------------------------------
module tb_timed_decoder;

  logic       clk = 1'b0;
  logic       rst;

  logic       a_en, a_valid, a_ready, a_none, a_busy, a_done, a_err;
  logic [2:0] a_code;
  logic [7:0] a_y;

  logic       b_en, b_valid, b_ready, b_none, b_busy, b_done, b_err;
  logic [2:0] b_code;
  logic [5:0] b_y;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  timed_decoder dut_a (
    .clk      (clk),
    .rst      (rst),
    .en       (a_en),
    .in_valid (a_valid),
    .in_ready (a_ready),
    .in_code  (a_code),
    .in_none  (a_none),
    .y        (a_y),
    .busy     (a_busy),
    .done     (a_done),
    .err      (a_err)
  );

  timed_decoder #(
    .N_OUT       (6),
    .HOLD_CYCLES (1),
    .GAP_CYCLES  (0)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .en       (b_en),
    .in_valid (b_valid),
    .in_ready (b_ready),
    .in_code  (b_code),
    .in_none  (b_none),
    .y        (b_y),
    .busy     (b_busy),
    .done     (b_done),
    .err      (b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to the next falling edge and check the at-most-one-hot invariant.
  task automatic tick();
    @(negedge clk);
    check("onehot0_a", 32'($onehot0(a_y)), 32'd1);
    check("onehot0_b", 32'($onehot0(b_y)), 32'd1);
  endtask

  task automatic chk_a(input string tag, input logic [7:0] ey, input logic eb,
                       input logic ed);
    check({tag, "_y"},    32'(a_y),    32'(ey));
    check({tag, "_busy"}, 32'(a_busy), 32'(eb));
    check({tag, "_done"}, 32'(a_done), 32'(ed));
  endtask

  initial begin
    rst = 1'b1;
    a_en = 1'b1; a_valid = 1'b0; a_code = '0; a_none = 1'b0;
    b_en = 1'b1; b_valid = 1'b0; b_code = '0; b_none = 1'b0;
    tick(); tick();

    // Reset state, in_ready forced low while rst is high.
    chk_a("rst_a", 8'h00, 1'b0, 1'b0);
    check("rst_a_err",   32'(a_err),   32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_y",     32'(b_y),     32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(a_ready), 32'd1);

    // 1: code 5 -> 0x20 on cycles 1-4, done on 5, ready again on 6.
    a_valid = 1'b1; a_code = 3'd5;
    tick();
    a_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk_a("t1_hold", 8'h20, 1'b1, 1'b0);
      check("t1_ready_busy", 32'(a_ready), 32'd0);
      tick();
    end
    chk_a("t1_gap", 8'h00, 1'b1, 1'b1);
    check("t1_ready_gap", 32'(a_ready), 32'd0);
    tick();
    chk_a("t1_idle", 8'h00, 1'b0, 1'b0);
    check("t1_ready_idle", 32'(a_ready), 32'd1);

    // 2: valid held high, codes 0 then 7.
    a_valid = 1'b1; a_code = 3'd0;
    tick();
    a_code = 3'd7;
    for (int i = 1; i <= 4; i++) begin
      chk_a("t2_hold0", 8'h01, 1'b1, 1'b0);
      tick();
    end
    chk_a("t2_gap", 8'h00, 1'b1, 1'b1);
    tick();
    chk_a("t2_idle", 8'h00, 1'b0, 1'b0);
    check("t2_ready_idle", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    for (int i = 7; i <= 10; i++) begin
      chk_a("t2_hold7", 8'h80, 1'b1, 1'b0);
      tick();
    end
    chk_a("t2_gap7", 8'h00, 1'b1, 1'b1);
    tick();

    // 3: in_none wins over code 3; then en=0 blocks acceptance.
    a_valid = 1'b1; a_none = 1'b1; a_code = 3'd3;
    tick();
    a_valid = 1'b0; a_none = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk_a("t3_none", 8'h00, 1'b1, 1'b0);
      tick();
    end
    chk_a("t3_done", 8'h00, 1'b1, 1'b1);
    tick();
    a_en = 1'b0; a_valid = 1'b1; a_code = 3'd3;
    #1;
    check("t3_ready_en0", 32'(a_ready), 32'd0);
    tick();
    chk_a("t3_blocked1", 8'h00, 1'b0, 1'b0);
    tick();
    chk_a("t3_blocked2", 8'h00, 1'b0, 1'b0);
    a_valid = 1'b0; a_en = 1'b1;
    #1;
    check("t3_ready_en1", 32'(a_ready), 32'd1);

    // 4: accept code 2, drop en at cycle 2 -> abort, no done.
    a_valid = 1'b1; a_code = 3'd2;
    tick();
    a_valid = 1'b0;
    chk_a("t4_c1", 8'h04, 1'b1, 1'b0);
    tick();
    chk_a("t4_c2", 8'h04, 1'b1, 1'b0);
    a_en = 1'b0;
    tick();
    chk_a("t4_abort", 8'h00, 1'b0, 1'b0);
    check("t4_ready_en0", 32'(a_ready), 32'd0);
    tick();
    chk_a("t4_after", 8'h00, 1'b0, 1'b0);
    a_en = 1'b1;
    #1;
    check("t4_ready_en1", 32'(a_ready), 32'd1);

    // 5: rst during DRIVE of code 6.
    a_valid = 1'b1; a_code = 3'd6;
    tick();
    a_valid = 1'b0;
    chk_a("t5_c1", 8'h40, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("t5_ready_rst", 32'(a_ready), 32'd0);
    tick();
    chk_a("t5_reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("t5_ready_rel", 32'(a_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a("t5_quiet", 8'h00, 1'b0, 1'b0);
    end

    // X on in_code with in_valid low must not reach y.
    a_code = 3'bxxx;
    tick();
    chk_a("xcode", 8'h00, 1'b0, 1'b0);
    a_code = 3'd0;

    // 6: N_OUT=6, HOLD=1, GAP=0. Code 7 is out of range.
    b_valid = 1'b1; b_code = 3'd7;
    #1;
    check("t6_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    check("t6_oor_y",    32'(b_y),    32'd0);
    check("t6_oor_err",  32'(b_err),  32'd1);
    check("t6_oor_busy", 32'(b_busy), 32'd1);
    check("t6_oor_done", 32'(b_done), 32'd0);
    tick();
    check("t6_oor_done2", 32'(b_done),  32'd1);
    check("t6_oor_err2",  32'(b_err),   32'd0);
    check("t6_oor_idle",  32'(b_busy),  32'd0);
    check("t6_oor_rdy",   32'(b_ready), 32'd1);
    b_valid = 1'b1; b_code = 3'd4;
    tick();
    b_valid = 1'b0;
    check("t6_c4_y",   32'(b_y),   32'h10);
    check("t6_c4_err", 32'(b_err), 32'd0);
    tick();
    check("t6_c4_y2",   32'(b_y),    32'd0);
    check("t6_c4_done", 32'(b_done), 32'd1);
    tick();
    check("t6_c4_done2", 32'(b_done), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles at most.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
